// File: rtl/pong_game_if.sv
// Control/status bundle between the pong game sequencer and its neighbours.
interface pong_game_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               frame_tick;
  logic               start;
  logic               pause;
  logic               score_left;
  logic               score_right;
  logic               ball_hold;
  logic               ball_run;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_l;
  logic [SCORE_W-1:0] score_r;
  logic               game_over;
  logic               winner;
  logic [1:0]         state;

  // Environment side: buttons, frame tick and ball score pulses in, status out.
  modport master (
    output frame_tick, start, pause, score_left, score_right,
    input  ball_hold, ball_run, serve_dir, score_l, score_r, game_over, winner, state
  );

  // Sequencer side.
  modport slave (
    input  frame_tick, start, pause, score_left, score_right,
    output ball_hold, ball_run, serve_dir, score_l, score_r, game_over, winner, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve delay, scoring, pause and winner detection.
module pong_game_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned SCORE_W      = 4
) (
  input logic        clk,
  input logic        reset,
  pong_game_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SERVE, S_PLAY, S_PAUSED, S_OVER
  } fsm_t;

  fsm_t               cur, nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SCORE_W-1:0] sl, sl_nxt, sr, sr_nxt, sl_inc, sr_inc;
  logic               dir, dir_nxt, win, win_nxt;
  logic               start_q, pause_q, start_rise, pause_rise;
  logic               hold, hold_nxt, run, run_nxt, over, over_nxt;
  logic [1:0]         code, code_nxt;

  assign start_rise = bus.start & ~start_q;
  assign pause_rise = bus.pause & ~pause_q;
  assign sl_inc     = sl + SCORE_W'(1);
  assign sr_inc     = sr + SCORE_W'(1);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) cur <= S_IDLE;
    else        cur <= nxt;
  end

  // Next-state, datapath and output decode.
  always_comb begin
    nxt     = cur;
    cnt_nxt = cnt;
    sl_nxt  = sl;
    sr_nxt  = sr;
    dir_nxt = dir;
    win_nxt = win;
    unique case (cur)
      S_IDLE: begin
        if (start_rise) begin
          sl_nxt  = '0;
          sr_nxt  = '0;
          cnt_nxt = '0;
          nxt     = S_SERVE;
        end
      end
      S_SERVE: begin
        if (bus.frame_tick) begin
          if (cnt == CNT_W'(SERVE_FRAMES - 1)) begin
            cnt_nxt = '0;
            nxt     = S_PLAY;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_PLAY: begin
        // A score pulse outranks a coincident pause press.
        if (bus.score_left && bus.score_right) begin
          dir_nxt = ~dir;
          nxt     = S_SERVE;
        end else if (bus.score_left) begin
          sl_nxt  = sl_inc;
          dir_nxt = 1'b1;
          if (sl_inc == SCORE_W'(WIN_SCORE)) begin
            win_nxt = 1'b0;
            nxt     = S_OVER;
          end else begin
            nxt = S_SERVE;
          end
        end else if (bus.score_right) begin
          sr_nxt  = sr_inc;
          dir_nxt = 1'b0;
          if (sr_inc == SCORE_W'(WIN_SCORE)) begin
            win_nxt = 1'b1;
            nxt     = S_OVER;
          end else begin
            nxt = S_SERVE;
          end
        end else if (pause_rise) begin
          nxt = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (start_rise)      nxt = S_IDLE;
        else if (pause_rise) nxt = S_PLAY;
      end
      S_OVER: begin
        if (start_rise) begin
          sl_nxt  = '0;
          sr_nxt  = '0;
          cnt_nxt = '0;
          nxt     = S_SERVE;
        end
      end
      default: nxt = S_IDLE;
    endcase

    hold_nxt = (nxt != S_PLAY) && (nxt != S_PAUSED);
    run_nxt  = (nxt == S_PLAY);
    over_nxt = (nxt == S_OVER);
    case (nxt)
      S_SERVE:  code_nxt = 2'd1;
      S_PLAY:   code_nxt = 2'd2;
      S_PAUSED: code_nxt = 2'd3;
      default:  code_nxt = 2'd0;
    endcase
  end

  // Registered datapath, edge-detect history and outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      sl      <= '0;
      sr      <= '0;
      dir     <= 1'b0;
      win     <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      hold    <= 1'b1;
      run     <= 1'b0;
      over    <= 1'b0;
      code    <= 2'd0;
    end else begin
      cnt     <= cnt_nxt;
      sl      <= sl_nxt;
      sr      <= sr_nxt;
      dir     <= dir_nxt;
      win     <= win_nxt;
      start_q <= bus.start;
      pause_q <= bus.pause;
      hold    <= hold_nxt;
      run     <= run_nxt;
      over    <= over_nxt;
      code    <= code_nxt;
    end
  end

  assign bus.ball_hold = hold;
  assign bus.ball_run  = run;
  assign bus.serve_dir = dir;
  assign bus.score_l   = sl;
  assign bus.score_r   = sr;
  assign bus.game_over = over;
  assign bus.winner    = win;
  assign bus.state     = code;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed scoreboard bench for pong_game_ctrl (WIN_SCORE=3, SERVE_FRAMES=3).
module tb_pong_game_ctrl;
  typedef struct packed {
    logic [1:0] st;
    logic       hold;
    logic       run;
    logic       dir;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       over;
    logic       win;
  } obs_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  obs_t  exp_q[$];
  string tag_q[$];

  pong_game_if #(.SCORE_W(4)) bus ();

  pong_game_ctrl #(.WIN_SCORE(3), .SERVE_FRAMES(3), .SCORE_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] st, input logic hold, input logic run,
                              input logic dir, input logic [3:0] sl, input logic [3:0] sr,
                              input logic over, input logic win);
    obs_t o;
    o.st = st; o.hold = hold; o.run = run; o.dir = dir;
    o.sl = sl; o.sr = sr; o.over = over; o.win = win;
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(bus.state, bus.ball_hold, bus.ball_run, bus.serve_dir,
              bus.score_l, bus.score_r, bus.game_over, bus.winner);
  endfunction

  // Push the expectation for the coming edge, advance, then pop and compare.
  task automatic step(input string tag, input obs_t e);
    obs_t  ex;
    obs_t  ob;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    ex = exp_q.pop_front();
    t  = tag_q.pop_front();
    ob = observe();
    checks++;
    assert (ob === ex) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", t, ob, ex);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Three back-to-back frame ticks: two in SERVE, the third launches PLAY.
  task automatic serve3(input logic dir, input logic [3:0] sl, input logic [3:0] sr,
                        input logic win);
    bus.frame_tick = 1'b1;
    step("serve_f1", mk(2'd1, 1'b1, 1'b0, dir, sl, sr, 1'b0, win));
    step("serve_f2", mk(2'd1, 1'b1, 1'b0, dir, sl, sr, 1'b0, win));
    step("serve_f3", mk(2'd2, 1'b0, 1'b1, dir, sl, sr, 1'b0, win));
    bus.frame_tick = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.start = 1'b1;
    bus.pause = 1'b0;
    bus.frame_tick = 1'b0;
    bus.score_left = 1'b0;
    bus.score_right = 1'b0;

    // Reset held with start asserted.
    idle(2);
    step("reset", mk(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    reset = 1'b1;
    bus.start = 1'b0;
    idle(2);
    step("idle_hold", mk(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));

    // Start press enters SERVE; ticks spaced 10 cycles apart.
    bus.start = 1'b1;
    step("start_serve", mk(2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(9);
      bus.frame_tick = 1'b1;
      if (i < 2) step("serve_wait", mk(2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
      else       step("serve_done", mk(2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
      bus.frame_tick = 1'b0;
    end
    bus.frame_tick = 1'b1;
    step("tick_in_play", mk(2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    bus.frame_tick = 1'b0;

    // Left point, then right point.
    bus.score_left = 1'b1;
    step("left_point", mk(2'd1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0));
    bus.score_left = 1'b0;
    serve3(1'b1, 4'd1, 4'd0, 1'b0);
    bus.score_right = 1'b1;
    step("right_point", mk(2'd1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0));
    bus.score_right = 1'b0;
    serve3(1'b0, 4'd1, 4'd1, 1'b0);

    // Simultaneous score pulses replay the point.
    bus.score_left = 1'b1;
    bus.score_right = 1'b1;
    step("replay", mk(2'd1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0));
    bus.score_left = 1'b0;
    bus.score_right = 1'b0;
    serve3(1'b1, 4'd1, 4'd1, 1'b0);

    // Score and pause together: score wins.
    bus.score_right = 1'b1;
    bus.pause = 1'b1;
    step("score_vs_pause", mk(2'd1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0));
    bus.score_right = 1'b0;
    bus.pause = 1'b0;
    serve3(1'b0, 4'd1, 4'd2, 1'b0);

    // Winning point and game over behaviour.
    bus.score_right = 1'b1;
    step("win_right", mk(2'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b1));
    bus.score_right = 1'b0;
    bus.score_left = 1'b1;
    step("over_ign_l", mk(2'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b1));
    bus.score_left = 1'b0;
    bus.score_right = 1'b1;
    step("over_ign_r", mk(2'd0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd3, 1'b1, 1'b1));
    bus.score_right = 1'b0;
    bus.start = 1'b1;
    step("restart", mk(2'd1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1));
    bus.start = 1'b0;
    serve3(1'b0, 4'd0, 4'd0, 1'b1);

    // Pause / resume, score ignored while paused.
    bus.pause = 1'b1;
    step("pause", mk(2'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1));
    step("pause_level", mk(2'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1));
    bus.pause = 1'b0;
    bus.score_left = 1'b1;
    bus.frame_tick = 1'b1;
    step("paused_ign", mk(2'd3, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1));
    bus.score_left = 1'b0;
    bus.frame_tick = 1'b0;
    bus.pause = 1'b1;
    step("resume", mk(2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1));
    bus.pause = 1'b0;

    // Start while paused returns to IDLE keeping scores.
    bus.score_left = 1'b1;
    step("left_again", mk(2'd1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1));
    bus.score_left = 1'b0;
    serve3(1'b1, 4'd1, 4'd0, 1'b1);
    bus.pause = 1'b1;
    step("pause2", mk(2'd3, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1));
    bus.pause = 1'b0;
    bus.start = 1'b1;
    step("paused_quit", mk(2'd0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1));
    bus.start = 1'b0;
    idle(1);
    bus.start = 1'b1;
    step("idle_start", mk(2'd1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1));
    bus.start = 1'b0;
    serve3(1'b1, 4'd0, 4'd0, 1'b1);

    // Reset mid-play.
    bus.score_left = 1'b1;
    step("pre_reset", mk(2'd1, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b1));
    bus.score_left = 1'b0;
    serve3(1'b1, 4'd1, 4'd0, 1'b1);
    reset = 1'b0;
    bus.score_right = 1'b1;
    step("reset_play", mk(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));
    bus.score_right = 1'b0;
    reset = 1'b1;
    step("post_reset", mk(2'd0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
